// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-word sweep sequencer for a DDS phase accumulator.
// Steps KW_Out from start toward stop, holding each word for dwell+1 cycles and
// clamping the final word to stop. Supports repeat, abort and single-point sweeps.
// Optional macro DDS_SWEEP_WAVE_CYCLE_EN: the waveform select loads on start and
// advances 0->1->2->0 at each sweep end. Without it, the select is a registered copy
// of the input.
module dds_sweep_ctrl #(
   parameter int unsigned KW_W    = 12,
   parameter int unsigned DWELL_W = 16
) (
   input  logic               CLK,
   input  logic               RSTn,
   input  logic               Start_In,
   input  logic               Abort_In,
   input  logic               Repeat_In,
   input  logic [KW_W-1:0]    KW_Start_In,
   input  logic [KW_W-1:0]    KW_Stop_In,
   input  logic [KW_W-1:0]    KW_Step_In,
   input  logic [DWELL_W-1:0] Dwell_In,
   input  logic [1:0]         Wave_Sel_In,
   output logic [KW_W-1:0]    KW_Out,
   output logic [1:0]         Wave_Sel_Out,
   output logic               Busy_Out,
   output logic               Done_Out
);

   typedef enum logic [1:0] {StIdle, StSweep, StLast} state_e;

   state_e             state_q, state_d;
   logic [KW_W-1:0]    kw_q, kw_d;
   logic [KW_W-1:0]    start_q, start_d;
   logic [KW_W-1:0]    stop_q, stop_d;
   logic [KW_W-1:0]    step_q, step_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [1:0]         wave_q, wave_d;
   logic [KW_W:0]      next_sum;
   logic               start_acc;

   // Next-state, datapath and sweep-end decode
   always_comb begin
      state_d   = state_q;
      kw_d      = kw_q;
      start_d   = start_q;
      stop_d    = stop_q;
      step_d    = step_q;
      dwell_d   = dwell_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      start_acc = 1'b0;
      // One extra bit so an overshoot past the top of the range clamps instead of wrapping
      next_sum  = {1'b0, kw_q} + {1'b0, step_q};

      if (Abort_In) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (Start_In) begin
                  start_acc = 1'b1;
                  start_d   = KW_Start_In;
                  stop_d    = KW_Stop_In;
                  step_d    = (KW_Step_In == '0) ? KW_W'(1) : KW_Step_In;
                  dwell_d   = Dwell_In;
                  kw_d      = KW_Start_In;
                  cnt_d     = Dwell_In;
                  state_d   = (KW_Stop_In <= KW_Start_In) ? StLast : StSweep;
               end
            end
            StSweep: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - DWELL_W'(1);
               end else begin
                  cnt_d = dwell_q;
                  if (next_sum < {1'b0, stop_q}) begin
                     kw_d = next_sum[KW_W-1:0];
                  end else begin
                     kw_d    = stop_q;
                     state_d = StLast;
                  end
               end
            end
            StLast: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - DWELL_W'(1);
               end else begin
                  done_d = 1'b1;
                  if (Repeat_In) begin
                     kw_d  = start_q;
                     cnt_d = dwell_q;
                     // A single-point sweep repeats as single-point rather than clamping to stop
                     state_d = (stop_q <= start_q) ? StLast : StSweep;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

`ifdef DDS_SWEEP_WAVE_CYCLE_EN
   // Waveform select: load on accepted start, advance on each sweep end
   always_comb begin
      wave_d = wave_q;
      if (start_acc) begin
         wave_d = Wave_Sel_In;
      end else if (done_d) begin
         wave_d = (wave_q >= 2'd2) ? 2'd0 : wave_q + 2'd1;
      end
   end
`else
   // Waveform select: plain registered copy of the user select
   always_comb begin
      wave_d = Wave_Sel_In;
   end
`endif

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= StIdle;
         kw_q    <= '0;
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         dwell_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         wave_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         kw_q    <= kw_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         step_q  <= step_d;
         dwell_q <= dwell_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         wave_q  <= wave_d;
      end
   end

   // Output mapping
   always_comb begin
      KW_Out       = kw_q;
      Wave_Sel_Out = wave_q;
      Busy_Out     = (state_q != StIdle);
      Done_Out     = done_q;
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed vector table, hand-written
// abort/reset/repeat sequences, and a randomized run against a schedule-based model.
module tb_dds_sweep_ctrl;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        Start_In, Abort_In, Repeat_In;
   logic [11:0] KW_Start_In, KW_Stop_In, KW_Step_In;
   logic [15:0] Dwell_In;
   logic [1:0]  Wave_Sel_In;
   logic [11:0] KW_Out;
   logic [1:0]  Wave_Sel_Out;
   logic        Busy_Out, Done_Out;

   int total = 0;
   int bad   = 0;

   dds_sweep_ctrl #(.KW_W(12), .DWELL_W(16)) dut (
      .CLK(CLK), .RSTn(RSTn), .Start_In(Start_In), .Abort_In(Abort_In),
      .Repeat_In(Repeat_In), .KW_Start_In(KW_Start_In), .KW_Stop_In(KW_Stop_In),
      .KW_Step_In(KW_Step_In), .Dwell_In(Dwell_In), .Wave_Sel_In(Wave_Sel_In),
      .KW_Out(KW_Out), .Wave_Sel_Out(Wave_Sel_Out), .Busy_Out(Busy_Out),
      .Done_Out(Done_Out)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int start; int stop; int step; int dwell; int n;
      int w0; int w1; int w2; int w3;
   } vec_t;

   typedef struct {
      int kw; int busy; int done;
   } exp_t;

   vec_t vecs[4];
   exp_t sched[$];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string name, input int kw, input int busy, input int done);
      check({name, ".kw"}, int'(KW_Out), kw);
      check({name, ".busy"}, int'(Busy_Out), busy);
      check({name, ".done"}, int'(Done_Out), done);
   endtask

   // Sweep as a list of words: start, then start+k*step clamped to stop, each held dwell+1
   // cycles, followed by the one-cycle done entry with the last word held.
   task automatic build_sched(input int st, input int sp, input int stp, input int dw);
      int w;
      int words[$];
      if (stp == 0) stp = 1;
      w = st;
      words.push_back(w);
      if (sp > st) begin
         while (w < sp) begin
            w = (w + stp < sp) ? w + stp : sp;
            words.push_back(w);
         end
      end
      sched.delete();
      foreach (words[i]) begin
         for (int d = 0; d <= dw; d++) sched.push_back('{words[i], 1, 0});
      end
      sched.push_back('{w, 0, 1});
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      @(negedge CLK);
      while (!Done_Out && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (!Done_Out) check({name, ".timeout"}, 0, 1);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RSTn = 1'b0;
      @(negedge CLK);
      RSTn = 1'b1;
   endtask

   initial begin
      exp_t cur, nxt;
      int   w[4];

      RSTn = 1'b0; Start_In = 0; Abort_In = 0; Repeat_In = 0;
      KW_Start_In = 0; KW_Stop_In = 0; KW_Step_In = 0; Dwell_In = 0; Wave_Sel_In = 0;

      vecs[0] = '{100, 130, 10, 2, 4, 100, 110, 120, 130};
      vecs[1] = '{4090, 4095, 8, 0, 2, 4090, 4095, 0, 0};
      vecs[2] = '{200, 100, 5, 1, 1, 200, 0, 0, 0};
      vecs[3] = '{5, 7, 0, 0, 3, 5, 6, 7, 0};

      // Reset state, before any clock edge
      #1;
      check_outs("reset", 0, 0, 0);
      check("reset.wave", int'(Wave_Sel_Out), 0);
      @(negedge CLK);
      RSTn = 1'b1;

      // Directed vectors; inputs scrambled after start to show they are ignored
      for (int v = 0; v < 4; v++) begin
         w = '{vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].w3};
         @(negedge CLK);
         KW_Start_In = 12'(vecs[v].start); KW_Stop_In = 12'(vecs[v].stop);
         KW_Step_In = 12'(vecs[v].step); Dwell_In = 16'(vecs[v].dwell);
         Start_In = 1;
         for (int i = 0; i < vecs[v].n; i++) begin
            for (int d = 0; d <= vecs[v].dwell; d++) begin
               @(negedge CLK);
               Start_In = 0;
               KW_Start_In = 12'($urandom); KW_Stop_In = 12'($urandom);
               KW_Step_In = 12'($urandom); Dwell_In = 16'($urandom);
               check_outs($sformatf("vec%0d.w%0d", v, i), w[i], 1, 0);
            end
         end
         @(negedge CLK);
         check_outs($sformatf("vec%0d.end", v), w[vecs[v].n - 1], 0, 1);
         @(negedge CLK);
         check_outs($sformatf("vec%0d.idle", v), w[vecs[v].n - 1], 0, 0);
      end

      // Abort mid-dwell together with Start
      @(negedge CLK);
      KW_Start_In = 100; KW_Stop_In = 130; KW_Step_In = 10; Dwell_In = 2;
      Start_In = 1;
      @(negedge CLK);
      Start_In = 0;
      @(negedge CLK);
      check_outs("abort.pre", 100, 1, 0);
      Abort_In = 1; Start_In = 1;
      @(negedge CLK);
      Abort_In = 0; Start_In = 0;
      check_outs("abort.next", 100, 0, 0);
      repeat (4) @(negedge CLK);
      check_outs("abort.stay", 100, 0, 0);

      // Asynchronous reset mid-sweep
      Wave_Sel_In = 2'd2;
      Start_In = 1;
      @(negedge CLK);
      Start_In = 0;
      repeat (4) @(negedge CLK);
      check_outs("rstmid.pre", 110, 1, 0);
      check("rstmid.pre.wave", int'(Wave_Sel_Out), 2);
      #2 RSTn = 1'b0;
      #1;
      check_outs("rstmid", 0, 0, 0);
      check("rstmid.wave", int'(Wave_Sel_Out), 0);
      @(negedge CLK);
      RSTn = 1'b1;
      Wave_Sel_In = 2'd0;

`ifndef DDS_SWEEP_WAVE_CYCLE_EN
      // Without cycling, the select is a one-cycle delayed copy of the input
      @(negedge CLK);
      Wave_Sel_In = 2'd1;
      check("wave.delay.old", int'(Wave_Sel_Out), 0);
      @(negedge CLK);
      check("wave.delay.new", int'(Wave_Sel_Out), 1);
      Wave_Sel_In = 2'd0;
      @(negedge CLK);
`endif

      // Repeat mode: Busy stays high across sweep ends, select cycles with the macro
      Repeat_In = 1;
      KW_Start_In = 5; KW_Stop_In = 7; KW_Step_In = 1; Dwell_In = 0; Wave_Sel_In = 0;
      Start_In = 1;
      @(negedge CLK);
      Start_In = 0;
      check("rep.wave0", int'(Wave_Sel_Out), 0);
      for (int k = 1; k <= 3; k++) begin
         wait_done($sformatf("rep%0d", k));
         check_outs($sformatf("rep%0d", k), 5, 1, 1);
`ifdef DDS_SWEEP_WAVE_CYCLE_EN
         check($sformatf("rep%0d.wave", k), int'(Wave_Sel_Out), k % 3);
`else
         check($sformatf("rep%0d.wave", k), int'(Wave_Sel_Out), 0);
`endif
      end
      Repeat_In = 0;
      wait_done("rep.final");
      check_outs("rep.final", 7, 0, 1);

      // Randomized run against the schedule model
      do_reset();
      cur = '{0, 0, 0};
      for (int c = 0; c < 4000; c++) begin
         @(negedge CLK);
         check_outs("rand", cur.kw, cur.busy, cur.done);
         Abort_In = ($urandom_range(0, 59) == 0);
         Start_In = ($urandom_range(0, 3) == 0);
         KW_Start_In = 12'($urandom);
         if ($urandom_range(0, 4) == 0) KW_Stop_In = 12'($urandom);
         else KW_Stop_In = (int'(KW_Start_In) + 40 > 4095) ? 12'd4095
                           : KW_Start_In + 12'($urandom_range(0, 40));
         KW_Step_In = 12'($urandom_range(0, 15));
         Dwell_In = 16'($urandom_range(0, 3));
         if (Abort_In) begin
            sched.delete();
            nxt = '{cur.kw, 0, 0};
         end else if (Start_In && cur.busy == 0) begin
            build_sched(int'(KW_Start_In), int'(KW_Stop_In), int'(KW_Step_In), int'(Dwell_In));
            nxt = sched.pop_front();
         end else if (sched.size() > 0) begin
            nxt = sched.pop_front();
         end else begin
            nxt = '{cur.kw, 0, 0};
         end
         cur = nxt;
      end
      @(negedge CLK);
      check_outs("rand.last", cur.kw, cur.busy, cur.done);
      Start_In = 0; Abort_In = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
